// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain pointer, full, level and overflow logic for an async FIFO.
// Define FIFO_WR_AFULL_EN to add the registered almost-full output wafull.
module fifo_wr_ctrl #(
    parameter int P_WIDTH     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LEVEL = 12
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               winc,
    input  logic [P_WIDTH:0]   rptr_gray,
    output logic [P_WIDTH-1:0] waddr,
    output logic [P_WIDTH:0]   wptr_gray,
    output logic               wfull,
    output logic [P_WIDTH:0]   wlevel,
    output logic               wovf
`ifdef FIFO_WR_AFULL_EN
   ,output logic               wafull
`endif
);

    if (P_WIDTH < 2) begin : g_bad_width
        $error("fifo_wr_ctrl: P_WIDTH must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("fifo_wr_ctrl: SYNC_STAGES must be >= 2");
    end
    if (AFULL_LEVEL < 0 || AFULL_LEVEL > 2**P_WIDTH) begin : g_bad_afull
        $error("fifo_wr_ctrl: AFULL_LEVEL out of range");
    end

    logic [P_WIDTH:0] wbin;
    logic [P_WIDTH:0] wbin_next;
    logic [P_WIDTH:0] wgray_next;
    logic [P_WIDTH:0] rq_s;
    logic [P_WIDTH:0] rbin_s;
    logic [P_WIDTH:0] wlevel_next;
    logic [P_WIDTH:0] full_cmp;
    logic             push;

    logic [SYNC_STAGES-1:0][P_WIDTH:0] rq;

    assign push  = winc & ~wfull;
    assign waddr = wbin[P_WIDTH-1:0];
    assign rq_s  = rq[SYNC_STAGES-1];

    // Next binary write pointer and its Gray encoding
    always_comb begin
        wbin_next  = wbin + {{P_WIDTH{1'b0}}, push};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
    end

    // Synchronized read pointer back to binary, plus the full pattern
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= P_WIDTH; i++) begin
            rbin_s[i] = ^(rq_s >> i);
        end
        full_cmp    = {~rq_s[P_WIDTH:P_WIDTH-1], rq_s[P_WIDTH-2:0]};
        wlevel_next = wbin_next - rbin_s;
    end

    // Plain flop chain bringing the read Gray pointer into wclk
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rq <= '0;
        end else begin
            rq <= {rq[SYNC_STAGES-2:0], rptr_gray};
        end
    end

    // Write pointer, full, level and sticky overflow state
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin      <= '0;
            wptr_gray <= '0;
            wfull     <= 1'b0;
            wlevel    <= '0;
            wovf      <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            wfull     <= (wgray_next == full_cmp);
            wlevel    <= wlevel_next;
            wovf      <= wovf | (winc & wfull);
        end
    end

`ifdef FIFO_WR_AFULL_EN
    // Almost-full follows the same next-level value as wlevel
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wafull <= 1'b0;
        end else begin
            wafull <= (wlevel_next >= (P_WIDTH+1)'(AFULL_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: scoreboard bench for the async FIFO write controller.
// Build with FIFO_WR_AFULL_EN defined to also exercise wafull.
module tb_fifo_wr_ctrl;

    localparam int PW = 4;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          winc;
    logic [PW:0]   rptr_gray;
    logic [PW-1:0] waddr;
    logic [PW:0]   wptr_gray;
    logic          wfull;
    logic [PW:0]   wlevel;
    logic          wovf;
`ifdef FIFO_WR_AFULL_EN
    logic          wafull;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] addr;
        logic [4:0] gray;
        logic       full;
        logic [4:0] level;
    } exp_t;

    exp_t sb[$];

    always #5 wclk = ~wclk;

    fifo_wr_ctrl #(
        .P_WIDTH    (PW),
        .SYNC_STAGES(2),
        .AFULL_LEVEL(12)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .winc     (winc),
        .rptr_gray(rptr_gray),
        .waddr    (waddr),
        .wptr_gray(wptr_gray),
        .wfull    (wfull),
        .wlevel   (wlevel),
        .wovf     (wovf)
`ifdef FIFO_WR_AFULL_EN
       ,.wafull   (wafull)
`endif
    );

    function automatic logic [4:0] g(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.addr  = waddr;
        o.gray  = wptr_gray;
        o.full  = wfull;
        o.level = wlevel;
        return o;
    endfunction

    task automatic edge1();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        winc   = 1'b0;
        wrst_n = 1'b0;
        edge1();
        edge1();
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t o;
        winc      = 1'b0;
        rptr_gray = '0;
        wrst_n    = 1'b1;
        #1 wrst_n = 1'b0;
        edge1();
        o = observed();
        checks++;
        if (o !== exp_t'(0) || wovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: got %h ovf=%b, expected 0", o, wovf);
        end
        wrst_n = 1'b1;
        winc   = 1'b1;
        repeat (5) edge1();
        checks++;
        if (waddr !== 4'd5) begin
            errors++;
            $display("FAIL pre_reset_addr: got %0d, expected 5", waddr);
        end
        #3;
        winc   = 1'b0;
        wrst_n = 1'b0;
        #1;
        o = observed();
        checks++;
        if (o !== exp_t'(0) || wovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h ovf=%b, expected 0", o, wovf);
        end
        edge1();
        wrst_n = 1'b1;
    endtask

    task automatic test_fill();
        exp_t e;
        exp_t o;
        rptr_gray = '0;
        for (int i = 1; i <= 16; i++) begin
            winc    = 1'b1;
            e.addr  = 4'(i % 16);
            e.gray  = g(i);
            e.full  = (i == 16);
            e.level = 5'(i);
            sb.push_back(e);
            edge1();
            o = observed();
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL fill[%0d]: got %h, expected %h", i, o, e);
            end
        end
        winc = 1'b0;
        checks++;
        if (wptr_gray !== 5'b11000) begin
            errors++;
            $display("FAIL fill_gray: got %b, expected 11000", wptr_gray);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        exp_t o;
        e = '{addr: 4'd0, gray: 5'b11000, full: 1'b1, level: 5'd16};
        for (int i = 0; i < 3; i++) begin
            winc = 1'b1;
            sb.push_back(e);
            edge1();
            o = observed();
            e = sb.pop_front();
            checks++;
            if (o !== e || wovf !== 1'b1) begin
                errors++;
                $display("FAIL ovf_hold[%0d]: got %h ovf=%b, expected %h ovf=1",
                         i, o, wovf, e);
            end
        end
        winc = 1'b0;
        repeat (2) edge1();
        checks++;
        if (wovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b, expected 1", wovf);
        end
    endtask

    task automatic test_pop_latency();
        exp_t e;
        exp_t o;
        rptr_gray = 5'b00001;
        for (int k = 1; k <= 3; k++) begin
            e = '{addr: 4'd0, gray: 5'b11000,
                  full: (k < 3), level: (k < 3) ? 5'd16 : 5'd15};
            sb.push_back(e);
            edge1();
            o = observed();
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pop_lat[%0d]: got %h, expected %h", k, o, e);
            end
        end
        winc = 1'b1;
        e    = '{addr: 4'd1, gray: 5'b11001, full: 1'b1, level: 5'd16};
        sb.push_back(e);
        edge1();
        winc = 1'b0;
        o    = observed();
        e    = sb.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL refill: got %h, expected %h", o, e);
        end
    endtask

    // Reader trails by one push; the synchronizer plus the level register
    // add three more edges, so the writer sees a steady level of 4.
    task automatic test_back_to_back();
        exp_t e;
        exp_t o;
        do_reset();
        rptr_gray = '0;
        for (int n = 1; n <= 40; n++) begin
            rptr_gray = g((n < 2) ? 0 : n - 2);
            winc      = 1'b1;
            e.addr    = 4'(n % 16);
            e.gray    = g(n);
            e.full    = 1'b0;
            e.level   = (n < 4) ? 5'(n) : 5'd4;
            sb.push_back(e);
            edge1();
            o = observed();
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stream[%0d]: got %h, expected %h", n, o, e);
            end
        end
        winc = 1'b0;
        checks++;
        if (wovf !== 1'b0) begin
            errors++;
            $display("FAIL stream_ovf: got %b, expected 0", wovf);
        end
    endtask

`ifdef FIFO_WR_AFULL_EN
    task automatic test_afull();
        do_reset();
        rptr_gray = '0;
        for (int n = 1; n <= 12; n++) begin
            winc = 1'b1;
            edge1();
            checks++;
            if (wafull !== (n >= 12)) begin
                errors++;
                $display("FAIL afull_rise[%0d]: got %b, expected %b",
                         n, wafull, (n >= 12));
            end
        end
        winc      = 1'b0;
        rptr_gray = g(1);
        for (int k = 1; k <= 3; k++) begin
            edge1();
            checks++;
            if (wafull !== (k < 3)) begin
                errors++;
                $display("FAIL afull_fall[%0d]: got %b, expected %b",
                         k, wafull, (k < 3));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_pop_latency();
        test_back_to_back();
`ifdef FIFO_WR_AFULL_EN
        test_afull();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
